// File: rtl/round_sequencer_pkg.sv
// Shared types and constants for the round sequencer.
//   state_t    : sequencer FSM states
//   STG_*      : stage indices, which are also the stg_sel / stg_start bit positions
package round_sequencer_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ISSUE,
    S_ARM,
    S_WAIT,
    S_NEXT,
    S_FINISH,
    S_ERROR
  } state_t;

  localparam logic [1:0] STG_ADDRC  = 2'd0;
  localparam logic [1:0] STG_SUB    = 2'd1;
  localparam logic [1:0] STG_MIX    = 2'd2;
  localparam int         NUM_STAGES = 3;

endpackage

// File: rtl/round_sequencer_watchdog.sv
// Per-stage watchdog for the round sequencer.
//   clk, rst : clock, asynchronous active-high reset
//   clear    : restart supervision (asserted in the issue cycle)
//   enable   : stage is being supervised (arm/wait cycles)
//   expired  : the count reaches TIMEOUT at the coming edge
module stage_watchdog #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] count;

  // The count is the number of cycles since the start pulse, so the issue
  // cycle itself loads 1 rather than 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      count <= '0;
    else if (clear)
      count <= CW'(1);
    else if (enable && count != CW'(TIMEOUT))
      count <= count + 1'b1;
  end

  assign expired = enable && (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/round_sequencer.sv
// Round scheduler for the encoder datapath: loads the input block, then runs
// ROUNDS rounds of addrc -> sub -> mix, each stage handshaked via
// start pulse / ready low / ready high, with a watchdog per stage.
//   start, abort : run request (IDLE only) / cancel run
//   stg_ready    : idle-ready from the three stage controllers
//   stg_start    : one-hot start pulse to the current stage
//   stg_sel      : current stage index (datapath mux select)
//   rc_idx       : current round index
//   ld_in, ld_st : load input block / capture stage output
//   ready, busy, done, err : status (done is a single-cycle pulse)
module round_sequencer
  import round_sequencer_pkg::*;
#(
  parameter int ROUNDS  = 12,
  parameter int RC_W    = 4,
  parameter int TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  input  logic [2:0]      stg_ready,
  output logic [2:0]      stg_start,
  output logic [1:0]      stg_sel,
  output logic [RC_W-1:0] rc_idx,
  output logic            ld_in,
  output logic            ld_st,
  output logic            ready,
  output logic            busy,
  output logic            done,
  output logic            err
);

  state_t          state, state_nxt;
  logic [RC_W-1:0] round, round_nxt;
  logic [1:0]      stage, stage_nxt;
  logic            wd_expired;
  logic [3:0]      rdy_pad;
  logic            cur_ready;

  // Padded so an index of 3 can never select outside the vector.
  assign rdy_pad   = {1'b0, stg_ready};
  assign cur_ready = rdy_pad[stage];

  stage_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
    .clk     (clk),
    .rst     (rst),
    .clear   (state == S_ISSUE),
    .enable  (state == S_ARM || state == S_WAIT),
    .expired (wd_expired)
  );

  always_comb begin
    state_nxt = state;
    round_nxt = round;
    stage_nxt = stage;
    if (abort && state != S_IDLE) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:   if (start) state_nxt = S_LOAD;
        S_LOAD: begin
          round_nxt = '0;
          stage_nxt = STG_ADDRC;
          state_nxt = S_ISSUE;
        end
        S_ISSUE:  state_nxt = S_ARM;
        S_ARM: begin
          if (wd_expired)      state_nxt = S_ERROR;
          else if (!cur_ready) state_nxt = S_WAIT;
        end
        S_WAIT: begin
          if (wd_expired)      state_nxt = S_ERROR;
          else if (cur_ready)  state_nxt = S_NEXT;
        end
        S_NEXT: begin
          if (stage != STG_MIX) begin
            stage_nxt = stage + 1'b1;
            state_nxt = S_ISSUE;
          end else if (round == RC_W'(ROUNDS - 1)) begin
            state_nxt = S_FINISH;
          end else begin
            round_nxt = round + 1'b1;
            stage_nxt = STG_ADDRC;
            state_nxt = S_ISSUE;
          end
        end
        S_FINISH: state_nxt = S_IDLE;
        S_ERROR:  state_nxt = S_ERROR;
        default:  state_nxt = S_IDLE;
      endcase
    end
  end

  // Outputs are registered decodes of the next state, so each one is a pure
  // function of the state register it lands alongside.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      round     <= '0;
      stage     <= STG_ADDRC;
      stg_start <= '0;
      ld_in     <= 1'b0;
      ld_st     <= 1'b0;
      ready     <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_nxt;
      round     <= round_nxt;
      stage     <= stage_nxt;
      stg_start <= (state_nxt == S_ISSUE) ? (3'b001 << stage_nxt) : 3'b000;
      ld_in     <= (state_nxt == S_LOAD);
      ld_st     <= (state_nxt == S_NEXT);
      ready     <= (state_nxt == S_IDLE);
      busy      <= (state_nxt != S_IDLE) && (state_nxt != S_ERROR);
      done      <= (state_nxt == S_FINISH);
      err       <= (state_nxt == S_ERROR);
    end
  end

  assign stg_sel = stage;
  assign rc_idx  = round;

endmodule

// File: tb/tb_round_sequencer.sv
module tb_round_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // dut a: ROUNDS=12, dut b: ROUNDS=1
  logic       start_a = 0, abort_a = 0, start_b = 0, abort_b = 0;
  logic [2:0] rdy_a, rdy_b, stg_start_a, stg_start_b;
  logic [1:0] stg_sel_a, stg_sel_b;
  logic [3:0] rc_idx_a, rc_idx_b;
  logic ld_in_a, ld_st_a, ready_a, busy_a, done_a, err_a;
  logic ld_in_b, ld_st_b, ready_b, busy_b, done_b, err_b;

  round_sequencer #(.ROUNDS(12), .RC_W(4), .TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .start(start_a), .abort(abort_a), .stg_ready(rdy_a),
    .stg_start(stg_start_a), .stg_sel(stg_sel_a), .rc_idx(rc_idx_a),
    .ld_in(ld_in_a), .ld_st(ld_st_a), .ready(ready_a), .busy(busy_a),
    .done(done_a), .err(err_a));

  round_sequencer #(.ROUNDS(1), .RC_W(4), .TIMEOUT(15)) dut1 (
    .clk(clk), .rst(rst), .start(start_b), .abort(abort_b), .stg_ready(rdy_b),
    .stg_start(stg_start_b), .stg_sel(stg_sel_b), .rc_idx(rc_idx_b),
    .ld_in(ld_in_b), .ld_st(ld_st_b), .ready(ready_b), .busy(busy_b),
    .done(done_b), .err(err_b));

  int cyc = 0;
  always @(posedge clk) cyc++;

  // Stage controller model: 3-cycle stage, ready low for the two cycles
  // after start is sampled. stuck[d][i] makes a stage ignore start.
  int cnt [2][3] = '{default: 0};
  bit stuck [2][3] = '{default: 0};
  assign rdy_a = {cnt[0][2] == 0, cnt[0][1] == 0, cnt[0][0] == 0};
  assign rdy_b = {cnt[1][2] == 0, cnt[1][1] == 0, cnt[1][0] == 0};

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      logic [2:0] ss;
      ss = (d == 0) ? stg_start_a : stg_start_b;
      for (int i = 0; i < 3; i++) begin
        if (rst) cnt[d][i] = 0;
        else begin
          if (cnt[d][i] > 0) cnt[d][i] = cnt[d][i] - 1;
          if (ss[i] && !stuck[d][i]) cnt[d][i] = 3;
        end
      end
    end
  end

  // Monitor
  int ldst_cnt = 0, ldin_cnt = 0, done_cnt = 0, done_cyc = 0;
  int nstarts = 0, ord_pos = 0, ord_err = 0;
  int done1_cnt = 0, done1_cyc = 0, rc1_bad = 0, ldst1_cnt = 0;
  always @(negedge clk) begin
    if (ld_st_a) ldst_cnt++;
    if (ld_in_a) begin ldin_cnt++; ord_pos = 0; end
    if (done_a) begin done_cnt++; done_cyc = cyc; end
    if (stg_start_a != 3'b000) begin
      logic [2:0] exp_oh;
      exp_oh = 3'b001 << (ord_pos % 3);
      if (stg_start_a != exp_oh || int'(stg_sel_a) != ord_pos % 3 ||
          int'(rc_idx_a) != ord_pos / 3) ord_err++;
      ord_pos++;
      nstarts++;
    end
    if (done_b) begin done1_cnt++; done1_cyc = cyc; end
    if (ld_st_b) ldst1_cnt++;
    if (rc_idx_b != 4'd0) rc1_bad++;
  end

  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [14:0] obs();
    return {ready_a, busy_a, ld_in_a, ld_st_a, done_a, err_a, stg_start_a, stg_sel_a, rc_idx_a};
  endfunction

  task automatic wait_done(input int base, input int budget);
    int n = 0;
    while (done_cnt == base && n < budget) begin @(negedge clk); n++; end
    chk("done_seen", 32'(done_cnt != base), 32'd1);
  endtask

  typedef struct {
    logic        start;
    logic        abort;
    logic [14:0] exp;   // {ready,busy,ld_in,ld_st,done,err, stg_start, stg_sel, rc_idx}
    string       name;
  } vec_t;

  localparam logic [14:0] RST_OBS = {6'b100000, 3'b000, 2'd0, 4'd0};

  initial begin
    vec_t v [8];
    int n_edge, n1, b_ldst, b_ldin, b_starts, b_done, issue_cyc, err_cyc, k;

    v[0] = '{1'b1, 1'b0, {6'b011000, 3'b000, 2'd0, 4'd0}, "load"};
    v[1] = '{1'b0, 1'b0, {6'b010000, 3'b001, 2'd0, 4'd0}, "issue_addrc"};
    v[2] = '{1'b0, 1'b0, {6'b010000, 3'b000, 2'd0, 4'd0}, "arm_addrc"};
    v[3] = '{1'b1, 1'b0, {6'b010000, 3'b000, 2'd0, 4'd0}, "wait1_busy_start"};
    v[4] = '{1'b0, 1'b0, {6'b010000, 3'b000, 2'd0, 4'd0}, "wait2_addrc"};
    v[5] = '{1'b0, 1'b0, {6'b010100, 3'b000, 2'd0, 4'd0}, "next_addrc"};
    v[6] = '{1'b0, 1'b0, {6'b010000, 3'b010, 2'd1, 4'd0}, "issue_sub"};
    v[7] = '{1'b0, 1'b0, {6'b010000, 3'b000, 2'd1, 4'd0}, "arm_sub"};

    // Reset state
    @(negedge clk);
    chk("reset_outputs", 32'(obs()), 32'(RST_OBS));
    rst = 1'b0;
    @(negedge clk);

    // ROUNDS=1 run
    start_b = 1'b1; n1 = cyc + 1;
    @(negedge clk); start_b = 1'b0;
    k = 0;
    while (done1_cnt == 0 && k < 60) begin @(negedge clk); k++; end
    chk("r1_done_cycle", 32'(done1_cyc - n1), 32'd16);
    chk("r1_ld_st_count", 32'(ldst1_cnt), 32'd3);
    chk("r1_rc_idx_zero", 32'(rc1_bad), 32'd0);

    // Full run, first cycles table-driven (includes a start while busy)
    b_ldst = ldst_cnt; b_ldin = ldin_cnt; b_starts = nstarts; b_done = done_cnt;
    n_edge = cyc + 1;
    for (int i = 0; i < 8; i++) begin
      start_a = v[i].start; abort_a = v[i].abort;
      @(negedge clk);
      chk(v[i].name, 32'(obs()), 32'(v[i].exp));
    end
    start_a = 1'b0;
    wait_done(b_done, 400);
    chk("done_cycle", 32'(done_cyc - n_edge), 32'd181);
    chk("ld_st_count", 32'(ldst_cnt - b_ldst), 32'd36);
    chk("ld_in_count", 32'(ldin_cnt - b_ldin), 32'd1);
    chk("start_count", 32'(nstarts - b_starts), 32'd36);
    chk("start_order", 32'(ord_err), 32'd0);
    @(negedge clk);
    chk("idle_hold_idx", 32'({ready_a, done_a, stg_sel_a, rc_idx_a}), 32'({1'b1, 1'b0, 2'd2, 4'd11}));

    // Watchdog: sub stage never drops ready
    stuck[0][1] = 1'b1;
    b_done = done_cnt;
    start_a = 1'b1; @(negedge clk); start_a = 1'b0;
    k = 0;
    while (stg_start_a != 3'b010 && k < 50) begin @(negedge clk); k++; end
    chk("wd_sub_issued", 32'(stg_start_a), 32'b010);
    issue_cyc = cyc;
    k = 0;
    while (!err_a && k < 40) begin @(negedge clk); k++; end
    err_cyc = cyc;
    chk("wd_err_latency", 32'(err_cyc - issue_cyc), 32'd15);
    chk("wd_err_status", 32'({err_a, busy_a, ready_a}), 32'b100);
    repeat (3) @(negedge clk);
    chk("wd_err_held", 32'({err_a, done_cnt != b_done}), 32'b10);
    abort_a = 1'b1; @(negedge clk); abort_a = 1'b0;
    chk("wd_abort_idle", 32'({ready_a, err_a, busy_a}), 32'b100);
    stuck[0][1] = 1'b0;
    repeat (4) @(negedge clk);

    // Abort in round 5, mix WAIT
    b_done = done_cnt;
    start_a = 1'b1; @(negedge clk); start_a = 1'b0;
    k = 0;
    while (!(stg_start_a == 3'b100 && rc_idx_a == 4'd5) && k < 200) begin @(negedge clk); k++; end
    @(negedge clk); @(negedge clk);
    chk("ab_in_wait", 32'({busy_a, ld_st_a, stg_sel_a, rc_idx_a}), 32'({1'b1, 1'b0, 2'd2, 4'd5}));
    abort_a = 1'b1; b_ldst = ldst_cnt;
    @(negedge clk); abort_a = 1'b0;
    chk("ab_idle", 32'({ready_a, busy_a}), 32'b10);
    repeat (20) @(negedge clk);
    chk("ab_no_ld_st", 32'(ldst_cnt - b_ldst), 32'd0);
    chk("ab_no_done", 32'(done_cnt - b_done), 32'd0);

    // start+abort together in IDLE -> LOAD, restart at round 0
    start_a = 1'b1; abort_a = 1'b1;
    @(negedge clk); start_a = 1'b0; abort_a = 1'b0;
    chk("sa_load", 32'({ld_in_a, busy_a}), 32'b11);
    @(negedge clk);
    chk("sa_restart_idx", 32'({stg_start_a, stg_sel_a, rc_idx_a}), 32'({3'b001, 2'd0, 4'd0}));

    // rst mid-run in round 3
    k = 0;
    while (rc_idx_a != 4'd3 && k < 100) begin @(negedge clk); k++; end
    chk("rst_reached_r3", 32'(rc_idx_a), 32'd3);
    rst = 1'b1; #1;
    chk("rst_immediate", 32'(obs()), 32'(RST_OBS));
    @(negedge clk); rst = 1'b0;
    @(negedge clk);

    // Run after reset completes normally
    b_ldst = ldst_cnt; b_done = done_cnt;
    start_a = 1'b1; n_edge = cyc + 1;
    @(negedge clk); start_a = 1'b0;
    wait_done(b_done, 400);
    chk("post_rst_done_cycle", 32'(done_cyc - n_edge), 32'd181);
    chk("post_rst_ld_st", 32'(ldst_cnt - b_ldst), 32'd36);
    chk("post_rst_order", 32'(ord_err), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
